// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, address+W, register index, two data bytes, STOP.
// SCL/SDA are open-drain; the block only ever pulls a line low or releases it.
module i2c_write_master #(
    parameter logic [15:0] P_QUARTER_CYCLES = 16'd125
) (
    input  logic       I_CLK,
    input  logic       I_NRESET,
    input  logic       I_START,
    input  logic [6:0] I_DEV_ADDRESS,
    input  logic [7:0] I_REG_ADDRESS,
    input  logic [15:0] I_DATA,
    output logic       O_BUSY,
    output logic       O_DONE,
    output logic       O_ACK_ERROR,
    inout  wire        IO_SCL,
    inout  wire        IO_SDA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] qcnt;
    logic [1:0]  quarter;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] frame;
    logic        nack;
    logic        wrap;
    logic        slot_end;
    logic        scl_low;
    logic        sda_low;

    assign wrap     = (qcnt == P_QUARTER_CYCLES - 16'd1);
    assign slot_end = wrap && (quarter == 2'd3);

    // Byte 0 sits in frame[31:24], so inverting byte_idx selects the right byte.
    always_comb begin
        state_next = state;
        scl_low    = 1'b0;
        sda_low    = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_START) state_next = S_START;
            end
            S_START: begin
                sda_low = (quarter >= 2'd2);
                scl_low = (quarter == 2'd3);
                if (slot_end) state_next = S_BIT;
            end
            S_BIT: begin
                scl_low = (quarter < 2'd2);
                sda_low = ~frame[{~byte_idx, bit_idx}];
                if (slot_end && bit_idx == 3'd0) state_next = S_ACK;
            end
            S_ACK: begin
                scl_low = (quarter < 2'd2);
                if (slot_end) state_next = (nack || byte_idx == 2'd3) ? S_STOP : S_BIT;
            end
            S_STOP: begin
                scl_low = (quarter == 2'd0);
                sda_low = (quarter < 2'd2);
                if (slot_end) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state       <= S_IDLE;
            qcnt        <= 16'd0;
            quarter     <= 2'd0;
            bit_idx     <= 3'd7;
            byte_idx    <= 2'd0;
            frame       <= 32'd0;
            nack        <= 1'b0;
            O_BUSY      <= 1'b0;
            O_DONE      <= 1'b0;
            O_ACK_ERROR <= 1'b0;
        end else begin
            state  <= state_next;
            O_DONE <= (state == S_DONE);
            if (state == S_IDLE) begin
                qcnt     <= 16'd0;
                quarter  <= 2'd0;
                bit_idx  <= 3'd7;
                byte_idx <= 2'd0;
                if (I_START) begin
                    frame       <= {I_DEV_ADDRESS, 1'b0, I_REG_ADDRESS, I_DATA};
                    O_BUSY      <= 1'b1;
                    O_ACK_ERROR <= 1'b0;
                    nack        <= 1'b0;
                end
            end else begin
                if (state == S_DONE) O_BUSY <= 1'b0;
                qcnt <= wrap ? 16'd0 : qcnt + 16'd1;
                if (wrap) quarter <= quarter + 2'd1;
                // The slave's answer is taken on the last cycle of the SCL-high q2.
                if (state == S_ACK && quarter == 2'd2 && wrap && IO_SDA) begin
                    nack        <= 1'b1;
                    O_ACK_ERROR <= 1'b1;
                end
                if (slot_end) begin
                    if (state == S_BIT) bit_idx <= bit_idx - 3'd1;
                    if (state == S_ACK) byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    assign IO_SCL = scl_low ? 1'b0 : 1'bz;
    assign IO_SDA = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus decoder + ACKing slave, table and random writes.
module tb_i2c_write_master;

    localparam logic [8:0] TOK_START = 9'h100;
    localparam logic [8:0] TOK_STOP  = 9'h101;

    logic        clk = 1'b0;
    logic        I_NRESET;
    logic        I_START;
    logic [6:0]  I_DEV_ADDRESS;
    logic [7:0]  I_REG_ADDRESS;
    logic [15:0] I_DATA;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_ACK_ERROR;
    wire         scl_w;
    wire         sda_w;
    logic        slave_low = 1'b0;

    pullup pu_scl (scl_w);
    pullup pu_sda (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    i2c_write_master #(.P_QUARTER_CYCLES(16'd2)) dut (
        .I_CLK(clk),
        .I_NRESET(I_NRESET),
        .I_START(I_START),
        .I_DEV_ADDRESS(I_DEV_ADDRESS),
        .I_REG_ADDRESS(I_REG_ADDRESS),
        .I_DATA(I_DATA),
        .O_BUSY(O_BUSY),
        .O_DONE(O_DONE),
        .O_ACK_ERROR(O_ACK_ERROR),
        .IO_SCL(scl_w),
        .IO_SDA(sda_w)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    // bus decoder and slave, sampled mid-cycle
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    int   bitcnt = 0;
    int   byte_no = 0;
    int   nack_byte = -1;
    logic [7:0] shreg = 8'd0;

    always @(negedge clk) begin
        if (prev_scl && scl_w && prev_sda && !sda_w) begin
            obs_q.push_back(TOK_START);
            bitcnt = 0;
            byte_no = 0;
            slave_low = 1'b0;
        end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
            obs_q.push_back(TOK_STOP);
            bitcnt = 0;
        end else if (!prev_scl && scl_w) begin
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], sda_w};
                bitcnt = bitcnt + 1;
            end else begin
                obs_q.push_back({1'b0, shreg});
                byte_no = byte_no + 1;
                bitcnt = 0;
            end
        end else if (prev_scl && !scl_w) begin
            slave_low = (bitcnt == 8) && (byte_no != nack_byte);
        end
        prev_scl = scl_w;
        prev_sda = sda_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // reference model: bytes on the wire, error flag and latency of one write
    task automatic model(input logic [6:0] dev, input logic [7:0] rg, input logic [15:0] dat,
                         input int nb, output logic err, output int cycles);
        logic [7:0] bytes[4];
        int last;
        bytes[0] = {dev, 1'b0};
        bytes[1] = rg;
        bytes[2] = dat[15:8];
        bytes[3] = dat[7:0];
        last = (nb >= 0 && nb < 4) ? nb : 3;
        exp_q.delete();
        exp_q.push_back(TOK_START);
        for (int k = 0; k <= last; k++) exp_q.push_back({1'b0, bytes[k]});
        exp_q.push_back(TOK_STOP);
        err = (nb >= 0 && nb < 4);
        cycles = 2 * (4 + 36 * (last + 1) + 4) + 1;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, " token count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, " token"}, {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
    endtask

    task automatic run_tx(input logic [6:0] dev, input logic [7:0] rg, input logic [15:0] dat,
                          input int nb, input int hold, input logic exp_err,
                          input int exp_cycles, input string tag);
        int cycles;
        int busy_drop;
        obs_q.delete();
        nack_byte = nb;
        @(negedge clk);
        I_START = 1'b1;
        I_DEV_ADDRESS = dev;
        I_REG_ADDRESS = rg;
        I_DATA = dat;
        @(posedge clk);
        #1;
        check({tag, " busy after accept"}, O_BUSY, 1);
        check({tag, " err cleared on accept"}, O_ACK_ERROR, 0);
        I_DEV_ADDRESS = 7'($urandom);
        I_REG_ADDRESS = 8'($urandom);
        I_DATA = 16'($urandom);
        cycles = 0;
        busy_drop = 0;
        while (!O_DONE && cycles < 2000) begin
            if (cycles >= hold) I_START = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            if (!O_DONE && !O_BUSY) busy_drop++;
        end
        I_START = 1'b0;
        check({tag, " latency"}, cycles, exp_cycles);
        check({tag, " busy drop early"}, busy_drop, 0);
        check({tag, " busy at done"}, O_BUSY, 0);
        check({tag, " ack_error"}, O_ACK_ERROR, {31'd0, exp_err});
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, O_DONE, 0);
        check({tag, " ack_error held"}, O_ACK_ERROR, {31'd0, exp_err});
        check({tag, " scl idle"}, scl_w, 1);
        check({tag, " sda idle"}, sda_w, 1);
        compare_stream(tag);
    endtask

    typedef struct {
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [15:0] dat;
        int          nb;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic m_err;
        int   m_cyc;
        int   cycles;

        vecs[0] = '{7'h50, 8'h03, 16'hBEEF, -1, 1'b0, 305};
        vecs[1] = '{7'h50, 8'h03, 16'hBEEF,  0, 1'b1, 89};
        vecs[2] = '{7'h2A, 8'h5A, 16'hA55A,  1, 1'b1, 161};
        vecs[3] = '{7'h7F, 8'hFF, 16'h0000,  2, 1'b1, 233};
        vecs[4] = '{7'h00, 8'h00, 16'hFFFF,  3, 1'b1, 305};

        I_NRESET = 1'b0;
        I_START = 1'b0;
        I_DEV_ADDRESS = 7'd0;
        I_REG_ADDRESS = 8'd0;
        I_DATA = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", O_BUSY, 0);
        check("reset done", O_DONE, 0);
        check("reset ack_error", O_ACK_ERROR, 0);
        check("reset scl", scl_w, 1);
        check("reset sda", sda_w, 1);
        @(negedge clk);
        I_NRESET = 1'b1;

        for (int i = 0; i < 5; i++) begin
            model(vecs[i].dev, vecs[i].rg, vecs[i].dat, vecs[i].nb, m_err, m_cyc);
            run_tx(vecs[i].dev, vecs[i].rg, vecs[i].dat, vecs[i].nb, 0,
                   vecs[i].exp_err, vecs[i].exp_cycles, $sformatf("vec%0d", i));
        end

        // start held high across a whole frame: one frame, then a second after busy falls
        model(7'h11, 8'h22, 16'h3344, -1, m_err, m_cyc);
        obs_q.delete();
        nack_byte = -1;
        @(negedge clk);
        I_START = 1'b1;
        I_DEV_ADDRESS = 7'h11;
        I_REG_ADDRESS = 8'h22;
        I_DATA = 16'h3344;
        @(posedge clk);
        #1;
        cycles = 0;
        while (!O_DONE && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("hold first latency", cycles, m_cyc);
        compare_stream("hold first");
        obs_q.delete();
        @(posedge clk);
        #1;
        check("hold second accept", O_BUSY, 1);
        I_START = 1'b0;
        cycles = 0;
        while (!O_DONE && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("hold second latency", cycles, m_cyc);
        compare_stream("hold second");

        // reset pulse during the register byte while SCL is low
        obs_q.delete();
        nack_byte = -1;
        @(negedge clk);
        I_START = 1'b1;
        I_DEV_ADDRESS = 7'h50;
        I_REG_ADDRESS = 8'h03;
        I_DATA = 16'h1234;
        @(posedge clk);
        #1;
        I_START = 1'b0;
        repeat (96) @(posedge clk);
        #7;
        I_NRESET = 1'b0;
        #1;
        check("midreset scl", scl_w, 1);
        check("midreset sda", sda_w, 1);
        check("midreset busy", O_BUSY, 0);
        check("midreset done", O_DONE, 0);
        check("midreset ack_error", O_ACK_ERROR, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        I_NRESET = 1'b1;
        check("midreset token count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("midreset start token", {23'd0, obs_q[0]}, {23'd0, TOK_START});
            check("midreset addr token", {23'd0, obs_q[1]}, 32'hA0);
        end
        model(7'h50, 8'h03, 16'h1234, -1, m_err, m_cyc);
        run_tx(7'h50, 8'h03, 16'h1234, -1, 0, m_err, m_cyc, "after reset");

        // random writes against the model
        for (int i = 0; i < 8; i++) begin
            logic [6:0]  rdev;
            logic [7:0]  rrg;
            logic [15:0] rdat;
            int          r;
            int          nb;
            rdev = 7'($urandom);
            rrg = 8'($urandom);
            rdat = 16'($urandom);
            r = int'($urandom_range(0, 6));
            nb = (r < 4) ? r : -1;
            model(rdev, rrg, rdat, nb, m_err, m_cyc);
            run_tx(rdev, rrg, rdat, nb, int'($urandom_range(0, 60)), m_err, m_cyc,
                   $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
REQ-001 Parameter: P_QUARTER_CYCLES, default 16'd125, I_CLK cycles per quarter SCL period (50 MHz clock -> 100 kHz SCL); legal minimum 2.
REQ-002 Port: I_CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: I_NRESET  input  1  asynchronous active-low reset.
REQ-004 Port: I_START  input  1  transaction request, sampled each cycle.
REQ-005 Port: I_DEV_ADDRESS  input  7  7-bit I2C target address.
REQ-006 Port: I_REG_ADDRESS  input  8  target register index.
REQ-007 Port: I_DATA  input  16  write payload, sent high byte first.
REQ-008 Port: O_BUSY  output  1  high from the accept cycle until DONE asserts.
REQ-009 Port: O_DONE  output  1  one-cycle completion pulse.
REQ-010 Port: O_ACK_ERROR  output  1  sticky NACK flag for the last transaction.
REQ-011 Port: IO_SCL  inout  1  open-drain I2C clock.
REQ-012 Port: IO_SDA  inout  1  open-drain I2C data.

Function
REQ-013 Open-drain rule: the block SHALL drive IO_SCL/IO_SDA only as 1'b0 or 1'bz, never 1'b1.
REQ-014 Accept: I_START high while O_BUSY low SHALL latch all three input fields and set O_BUSY on the next edge; I_START while busy SHALL be ignored.
REQ-015 Timebase: a quarter counter SHALL count 0..P_QUARTER_CYCLES-1 while busy; every FSM phase advance occurs on its wrap.
REQ-016 FSM states: IDLE, START, BIT, ACK, STOP, DONE.
REQ-017 START (4 quarters): SCL high and SDA high for q0-q1, SDA low for q2, SCL low for q3.
REQ-018 Frame: 4 bytes, MSB first: {dev_addr,1'b0}, reg_addr, data[15:8], data[7:0]; each byte is followed by one ACK slot.
REQ-019 BIT/ACK slot (4 quarters): SCL low for q0-q1, high for q2-q3; SDA changes only at the start of q0; in ACK, SDA is released.
REQ-020 ACK sample: IO_SDA SHALL be sampled on the last cycle of q2; a value of 1 is a NACK.
REQ-021 NACK: set O_ACK_ERROR, skip remaining bytes, go directly to STOP.
REQ-022 STOP (4 quarters): SCL low and SDA low for q0, SCL high with SDA low for q1, SDA released for q2-q3.
REQ-023 DONE: O_DONE high for exactly one cycle after STOP, with O_BUSY falling on the same edge; then IDLE.
REQ-024 Latency, no NACK: 152 quarters (4 START + 36x4 bit/ACK + 4 STOP), then DONE, i.e. 152*P_QUARTER_CYCLES+1 cycles from the accept edge to O_DONE high.
REQ-025 O_ACK_ERROR SHALL clear on the next accepted I_START and hold otherwise.
REQ-026 No clock stretching and no arbitration; the SCL input value SHALL be ignored.
REQ-027 Idle bus: both lines released.

Reset
REQ-028 I_NRESET low SHALL asynchronously force IDLE, counters to 0, O_BUSY=0, O_DONE=0, O_ACK_ERROR=0, and IO_SCL=IO_SDA=z.
REQ-029 Reset mid-transaction SHALL release both lines immediately with no STOP generated; the first I_START after reset SHALL begin a fresh START.

Verification (P_QUARTER_CYCLES=2, pull-ups modelled, slave model ACKs unless stated)
REQ-030 Write dev=7'h50, reg=8'h03, data=16'hBEEF -> bus decodes START, A0, 03, BE, EF, STOP; O_DONE at accept+305 cycles; O_ACK_ERROR=0.
REQ-031 Slave NACKs the address byte -> STOP follows the first ACK slot, O_ACK_ERROR=1, O_DONE pulses once, reg and data bytes never appear.
REQ-032 I_START held high for the whole transaction -> exactly one frame; a second frame starts only after O_BUSY falls.
REQ-033 I_NRESET pulsed low during the reg byte -> lines z within the same cycle, all outputs 0; a new request afterwards completes normally.
REQ-034 Protocol checker over all tests -> SDA never changes while SCL is high except at START/STOP, and no line ever driven 1.
